// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared types and constants for the register-file dump controller.
//   dump_state_e      : controller states (IDLE, DUMP, DONE)
//   S_*               : same states as plain constants for the state register
//   DUMP_WORDS        : words per dump (pc, instr, r0..r31)
//   W_PC/W_INSTR/...  : word indices of the dump header and register block
//   word_to_sel()     : maps a word index to the register-file read index
package rf_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dump_state_e;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_DUMP = DUMP;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [5:0] DUMP_WORDS = 6'd34;
  localparam logic [5:0] W_PC       = 6'd0;
  localparam logic [5:0] W_INSTR    = 6'd1;
  localparam logic [5:0] W_REG0     = 6'd2;
  localparam logic [5:0] W_LAST     = DUMP_WORDS - 6'd1;

  // Register index for the word about to be loaded; 0 outside the register block.
  function automatic logic [4:0] word_to_sel(input logic [5:0] w);
    if (w >= W_REG0 && w <= W_LAST) return 5'(w - W_REG0);
    else                            return 5'd0;
  endfunction

endpackage

// File: rtl/dump_out_reg.sv
// dump_out_reg: single-entry valid/ready output register (data + last flag).
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : capture i_data/i_last and raise o_valid
//   i_ready        : sink accepts the held word this cycle
//   o_valid/o_data/o_last : held word toward the sink
// The caller only asserts i_load when the slot is empty or being drained,
// so a held word is never overwritten before it is accepted.
module dump_out_reg
  import rf_dump_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_ready,
  input  logic [DW-1:0] i_data,
  input  logic          i_last,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_last
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_last  <= i_last;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: post-run register-file dump controller on the CPU debug port.
// Triggers on a breakpoint PC or an IDLE cycle-count timeout, halts the CPU,
// then streams pc, instr and r0..r31 over a valid/ready interface.
//   i_clk, i_rstn        : clock, async active-low reset
//   i_pc, i_instr        : CPU program counter and instruction at pc
//   i_reg_data           : register-file read data for o_reg_sel (combinational)
//   o_reg_sel            : register-file read index
//   o_cpu_halt           : freezes CPU while high
//   o_out_valid/i_out_ready/o_out_data/o_out_last : dump word stream
//   o_done, o_timeout    : sticky completion / timeout-cause flags
//
// state | meaning
// IDLE  | counting cycles, watching pc for breakpoint or timeout
// DUMP  | cpu halted, streaming 34 words
// DONE  | dump complete, cpu held halted until reset
module rf_dump_ctrl
  import rf_dump_pkg::*;
#(
  parameter logic [31:0] BREAK_PC   = 32'h0000_0048,
  parameter int          MAX_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_reg_data,
  output logic [4:0]  o_reg_sel,
  output logic        o_cpu_halt,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_data,
  output logic        o_out_last,
  output logic        o_done,
  output logic        o_timeout
);

  localparam int               CNT_W   = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_w;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_timeout;

  logic        w_hit_pc;
  logic        w_hit_cnt;
  logic        w_trigger;
  logic        w_more;
  logic        w_load;
  logic        w_last_accept;
  logic [31:0] w_word;
  logic        w_last;

  assign w_hit_pc  = (i_pc == BREAK_PC);
  assign w_hit_cnt = (r_cnt == CNT_MAX);
  assign w_trigger = (r_state == S_IDLE) && (w_hit_pc || w_hit_cnt);

  assign w_more        = (r_w < DUMP_WORDS);
  assign w_load        = (r_state == S_DUMP) && w_more && (!o_out_valid || i_out_ready);
  // Once every word is loaded, the accept of the held word is the accept of r31.
  assign w_last_accept = (r_state == S_DUMP) && !w_more && o_out_valid && i_out_ready;

  always_comb begin
    w_word = i_reg_data;
    case (r_w)
      W_PC:    w_word = r_pc;
      W_INSTR: w_word = r_instr;
      W_REG0:  w_word = 32'h0;   // r0 is architecturally zero whatever the array returns
      default: w_word = i_reg_data;
    endcase
  end

  assign w_last = (r_w == W_LAST);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_w       <= W_PC;
      r_pc      <= '0;
      r_instr   <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_hit_cnt) r_cnt <= r_cnt + 1'b1;
          if (w_trigger) begin
            r_pc      <= i_pc;
            r_instr   <= i_instr;
            r_w       <= W_PC;
            r_timeout <= !w_hit_pc;   // breakpoint wins a same-cycle tie
            r_state   <= S_DUMP;
          end
        end
        S_DUMP: begin
          if (w_load)        r_w     <= r_w + 6'd1;
          if (w_last_accept) r_state <= S_DONE;
        end
        S_DONE: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  dump_out_reg #(.DW(32)) u_out (
    .i_clk   (i_clk),
    .i_rst_n (i_rstn),
    .i_load  (w_load),
    .i_ready (i_out_ready),
    .i_data  (w_word),
    .i_last  (w_last),
    .o_valid (o_out_valid),
    .o_data  (o_out_data),
    .o_last  (o_out_last)
  );

  assign o_reg_sel  = word_to_sel(r_w);
  assign o_cpu_halt = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_rf_dump_ctrl.sv
module tb_rf_dump_ctrl;

  localparam logic [31:0] BP   = 32'h0000_0048;
  localparam int          MAXC = 1000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pc, instr, reg_data, out_data;
  logic [4:0]  reg_sel;
  logic        cpu_halt, out_valid, out_ready, out_last, done, timeout;
  logic [31:0] rf [32];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign reg_data = rf[reg_sel];

  rf_dump_ctrl #(.BREAK_PC(BP), .MAX_CYCLES(MAXC)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_pc        (pc),
    .i_instr     (instr),
    .i_reg_data  (reg_data),
    .o_reg_sel   (reg_sel),
    .o_cpu_halt  (cpu_halt),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_last  (out_last),
    .o_done      (done),
    .o_timeout   (timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_reg_sel"},   32'(reg_sel),   32'h0);
    chk({tag, "_cpu_halt"},  32'(cpu_halt),  32'h0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_out_data"},  out_data,       32'h0);
    chk({tag, "_out_last"},  32'(out_last),  32'h0);
    chk({tag, "_done"},      32'(done),      32'h0);
    chk({tag, "_timeout"},   32'(timeout),   32'h0);
  endtask

  // One reset-to-done run. Model: trigger cycle T from the pc/counter rule,
  // expected word list, and k = words accepted so far.
  task automatic run_dump(input int bp_cyc, input int rdy_mode, input int abort_k,
                          output int f_halt, output int f_valid, output int f_done,
                          output int beats, output logic [31:0] w0, output logic [31:0] w2,
                          output logic to_seen);
    logic [31:0] words [34];
    logic [31:0] p;
    int T, k, n, after, wl;
    logic to_m, e_halt, e_str, e_valid, e_done, e_to;
    logic [4:0] e_sel;
    bit fin;
    T = -1; k = 0; n = 0; after = 0; to_m = 1'b0; fin = 1'b0;
    f_halt = -1; f_valid = -1; f_done = -1; beats = 0; w0 = '0; w2 = '1; to_seen = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = $urandom | 32'h1;
    for (int i = 0; i < 34; i++) words[i] = '0;

    @(negedge clk);
    rstn = 1'b0; pc = '0; instr = '0; out_ready = 1'b0;
    #1 chk_reset_outs("rst_hold");
    @(negedge clk);
    rstn = 1'b1;
    while (!fin) begin
      e_halt  = (T >= 0) && (n >= T + 1);
      e_str   = (T >= 0) && (n >= T + 2);
      e_valid = e_str && (k < 34);
      e_done  = (T >= 0) && (k == 34);
      e_to    = e_halt && to_m;
      wl      = e_str ? k + int'(e_valid) : 0;
      e_sel   = (wl >= 2 && wl <= 33) ? 5'(wl - 2) : 5'd0;

      chk("cpu_halt",  32'(cpu_halt),  32'(e_halt));
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("done",      32'(done),      32'(e_done));
      chk("timeout",   32'(timeout),   32'(e_to));
      chk("reg_sel",   32'(reg_sel),   32'(e_sel));
      if (e_valid) begin
        chk("out_data", out_data,      words[k]);
        chk("out_last", 32'(out_last), 32'(k == 33));
      end else if (!e_str) begin
        chk("idle_data", out_data,      32'h0);
        chk("idle_last", 32'(out_last), 32'h0);
      end

      if (cpu_halt  && f_halt  < 0) f_halt  = n;
      if (out_valid && f_valid < 0) f_valid = n;
      if (done      && f_done  < 0) f_done  = n;

      if (abort_k >= 0 && e_valid && k == abort_k) begin
        #2 rstn = 1'b0;
        #1 chk_reset_outs("async_rst");
        to_seen = timeout;
        return;
      end

      p = $urandom;
      if (p == BP) p = p ^ 32'h1;
      if (n == bp_cyc) p = BP;
      pc    = p;
      instr = $urandom;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 4 == 0) || (n % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase

      if (out_valid && out_ready) begin
        if (beats == 0) w0 = out_data;
        if (beats == 2) w2 = out_data;
        beats++;
      end

      if (T < 0 && (p == BP || n == MAXC)) begin
        T = n;
        to_m = (p != BP);
        words[0] = p;
        words[1] = instr;
        words[2] = 32'h0;
        for (int i = 1; i < 32; i++) words[i + 2] = rf[i];
      end else if (e_valid && out_ready) begin
        k++;
      end

      if (e_done) after++;
      if (after >= 3) fin = 1'b1;
      if (n > MAXC + 400) begin
        n_tests++;
        n_fail++;
        $display("FAIL bound: no dump completion by cycle %0d (accepted %0d, required 34)", n, k);
        fin = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    to_seen = timeout;
  endtask

  initial begin
    int fh, fv, fd, bt;
    logic [31:0] w0, w2;
    logic ts;
    pc = '0; instr = '0; out_ready = 1'b0; rstn = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // breakpoint at cycle 20, sink always ready
    run_dump(20, 0, -1, fh, fv, fd, bt, w0, w2, ts);
    chk("A_halt_edge",   32'(fh), 32'd21);
    chk("A_first_valid", 32'(fv), 32'd22);
    chk("A_done_edge",   32'(fd), 32'd56);
    chk("A_beats",       32'(bt), 32'd34);
    chk("A_word0",       w0,      BP);
    chk("A_word2",       w2,      32'h0);
    chk("A_timeout",     32'(ts), 32'h0);

    // ready pattern 1,0,0,1
    run_dump(37, 1, -1, fh, fv, fd, bt, w0, w2, ts);
    chk("B_beats", 32'(bt), 32'd34);
    chk("B_word0", w0,      BP);
    chk("B_word2", w2,      32'h0);

    // reset during beat 10
    run_dump(15, 0, 9, fh, fv, fd, bt, w0, w2, ts);
    chk("C_beats_before_rst", 32'(bt), 32'd9);

    // timeout right after the abort: counter must have restarted
    run_dump(-1, 0, -1, fh, fv, fd, bt, w0, w2, ts);
    chk("D_halt_edge",   32'(fh), 32'd1001);
    chk("D_first_valid", 32'(fv), 32'd1002);
    chk("D_done_edge",   32'(fd), 32'd1036);
    chk("D_beats",       32'(bt), 32'd34);
    chk("D_word2",       w2,      32'h0);
    chk("D_timeout",     32'(ts), 32'h1);

    // breakpoint in the same cycle as the timeout
    run_dump(MAXC, 0, -1, fh, fv, fd, bt, w0, w2, ts);
    chk("E_halt_edge", 32'(fh), 32'd1001);
    chk("E_word0",     w0,      BP);
    chk("E_timeout",   32'(ts), 32'h0);

    // random ready, random breakpoint
    for (int r = 0; r < 3; r++) begin
      run_dump(int'($urandom_range(3, 200)), 2, -1, fh, fv, fd, bt, w0, w2, ts);
      chk("F_beats", 32'(bt), 32'd34);
      chk("F_word0", w0,      BP);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_dump_ctrl.md
# rf_dump_ctrl

Post-run register-file dump controller attached to the single-cycle CPU top's debug port. It watches the CPU program counter and triggers on a breakpoint address or a cycle-count timeout. On trigger it halts the CPU and walks `reg_sel` through all 32 registers, streaming PC, instruction and r0..r31 out over a valid/ready interface. It is the synthesizable counterpart of the simulation-only end-of-run dump, feeding a UART or trace sink downstream.

## Interface
- `BREAK_PC`, 32'h0000_0048: PC value that triggers the dump.
- `MAX_CYCLES`, 1000: IDLE cycles after reset before a forced, timeout-flagged dump; width of the counter is $clog2(MAX_CYCLES+1).
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `pc`  in  32  CPU program counter.
- `instr`  in  32  CPU instruction at `pc`.
- `reg_data`  in  32  register-file read data for `reg_sel`, combinational, same cycle.
- `reg_sel`  out  5  register-file read index.
- `cpu_halt`  out  1  freezes CPU PC/register writes while high.
- `out_valid`  out  1  `out_data` holds a dump word.
- `out_ready`  in  1  sink accepts the word this cycle.
- `out_data`  out  32  dump word.
- `out_last`  out  1  qualifies the final word (r31).
- `done`  out  1  dump complete, sticky until reset.
- `timeout`  out  1  dump was caused by the cycle limit, sticky until reset.

## Operation
- States: IDLE, DUMP, DONE.
- IDLE:
  - Cycle counter increments every clock.
  - Trigger is `pc == BREAK_PC` or counter `== MAX_CYCLES`.
  - If both hold in the same cycle, the breakpoint wins and `timeout` stays 0.
  - On trigger: latch `pc` and `instr`, set `cpu_halt`, clear word index `w` to 0, go to DUMP.
- DUMP streams 34 words in this order:
  - w=0: latched pc.
  - w=1: latched instr.
  - w=2..33: r0..r31. r0 is forced to 32'h0 regardless of `reg_data`.
- Output register loads the next word when `!out_valid || out_ready` and words remain; `w` increments on each load.
- `reg_sel = w-2` when 2≤w≤33, else 0. `reg_data` is sampled on the same edge that loads it.
- While `out_valid && !out_ready`: `out_data`, `out_last` and `out_valid` hold stable, and `w` does not advance.
- `out_last` is high only with word 33.
- When the handshake of word 33 completes, go to DONE.
- DONE: `done`=1, `out_valid`=0, `cpu_halt` stays 1. Leaves only by reset.
- Reset at any time (including mid-dump): everything clears, `cpu_halt` drops, counter restarts from 0.

## Timing
- Reset values: `reg_sel`=0, `cpu_halt`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `done`=0, `timeout`=0.
- Trigger seen in cycle T → `cpu_halt` high from edge T+1 → first `out_valid` from edge T+2.
- With `out_ready` held high: 34 back-to-back beats, edges T+2..T+35.
- `done` high from the edge after the last handshake (T+36).
- Throughput is 1 word/cycle; any `out_ready` low cycle adds exactly one cycle of latency.
- Counter saturates at `MAX_CYCLES` and freezes outside IDLE.

## Structure
- Shared package `rf_dump_pkg`:
  - state enum {IDLE, DUMP, DONE};
  - `DUMP_WORDS`=34;
  - header indices `W_PC`=0, `W_INSTR`=1, `W_REG0`=2.
- One sub-module `dump_out_reg`: 32-bit data plus last flag, a valid/ready holding register with load enable. It is the only storage on the output path.

## Test plan
- `pc` reaches 32'h48 at cycle 20, `out_ready`=1:
  - `cpu_halt` at edge 21;
  - 34 beats with word0=32'h48, word1=instr, word2=0, word k+2=rf[k];
  - `out_last` on beat 34, `done` at the following edge, `timeout`=0.
- `pc` never equals 32'h48, `MAX_CYCLES`=1000: trigger at counter 1000, `timeout`=1, full 34-word dump.
- `pc`=32'h48 in the cycle where the counter hits `MAX_CYCLES`: dump occurs with `timeout`=0.
- `out_ready` toggles 1,0,0,1 repeatedly:
  - words unchanged during stalls;
  - no word lost or duplicated;
  - `reg_sel` never skips an index.
- `rstn` pulsed low during beat 10: all outputs return to reset values asynchronously, `cpu_halt`=0. After release, the counter restarts and a new breakpoint produces a full dump from word 0.
- Register r0 driven nonzero on `reg_data` by a fault model: word2 is still 32'h0.
